encoder_viterbi_dec: RTL
========================

ENCODER_VITERBI_DEC -- requirements
Module: encoder_viterbi_dec

Interface
REQ-001 Parameter KMAX, default 64, maximum info bits per block; legal range 1..KMAX.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 aclr_n  input  1  reset; synchronous, active-low.
REQ-004 K  input  7  info bits in next block; sampled on first accepted symbol of a block.
REQ-005 in_valid  input  1  symbol pair (xk, zk) present.
REQ-006 xk  input  1  received systematic bit, hard decision.
REQ-007 zk  input  1  received parity bit, hard decision.
REQ-008 in_ready  output  1  decoder accepts a symbol this cycle.
REQ-009 out_valid  output  1  out_bit valid.
REQ-010 out_ready  input  1  downstream accepts out_bit.
REQ-011 out_bit  output  1  decoded info bit, block order.
REQ-012 out_last  output  1  marks the K-th decoded bit.
REQ-013 pm_final  output  8  final path metric of state 0 (Hamming errors seen); valid while out_valid.
REQ-014 k_err  output  1  one-cycle pulse, illegal K rejected.

Function
REQ-015 The block SHALL be a hard-decision Viterbi decoder for the 8-state RSC code: state {q0,q1,q2} (index q0*4+q1*2+q2), fb=c^q1^q2, x=c, z=fb^q0^q2, next state {fb,q0,q1}, start state 0.
REQ-016 Each block SHALL be K info steps then 3 tail steps with fb forced 0 (x=q1^q2, z=q0^q2), i.e. K+3 symbol pairs, trellis ending in state 0.
REQ-017 FSM states: IDLE, ACS, TRACE, OUT; reset state IDLE.
REQ-018 IDLE: in_ready=1; accepted symbol with 1<=K<=KMAX latches K, is processed as step 0, moves to ACS (or TRACE if K+3=1, impossible); illegal K (0 or >KMAX): symbol dropped, k_err=1 next cycle, stay IDLE.
REQ-019 ACS: in_ready=1; one trellis step per accepted symbol; after step K+2 accepted go to TRACE; in_valid low stalls with no state change.
REQ-020 Branch metric SHALL be Hamming distance (0..2) between (xk,zk) and expected (x,z); tail steps SHALL consider only fb=0 branches.
REQ-021 Path metrics: 8 bits, saturating add at 255; at block start state 0=0, others=255.
REQ-022 Per next state, predecessors differ only in q2; survivor bit = chosen predecessor q2; tie chooses q2=0; survivor row of 8 bits stored per step (KMAX+3 rows).
REQ-023 TRACE: in_ready=0; starts cur=0 at step K+2, one step per cycle down to 0; p=survivor[t][cur], pred={cur.q1,cur.q2,p}, decoded bit for t<K is cur.q0^cur.q2^p, stored at buffer index t; exactly K+3 cycles, then OUT.
REQ-024 pm_final SHALL latch state-0 metric at end of ACS.
REQ-025 OUT: in_ready=0; out_valid=1; bits emitted index 0..K-1, advancing only when out_valid&out_ready; out_bit/out_last stable while stalled; out_last=1 only at index K-1; after last transfer return to IDLE with out_valid=0 next cycle.
REQ-026 Latency: first out_valid asserts K+3 cycles after the cycle the final tail symbol is accepted (no stalls).
REQ-027 Arbitrary gaps in in_valid and out_ready SHALL not change decoded results.

Reset
REQ-028 aclr_n low at any rising edge, including mid-ACS/TRACE/OUT: next cycle state IDLE, in_ready=1, out_valid=0, out_bit=0, out_last=0, pm_final=0, k_err=0, step counters 0, metrics re-initialised; partial block discarded.
REQ-029 Survivor and output buffers need no reset; never read before being written in the current block.

Verification
REQ-030 K=4, pairs (1,1),(0,1),(1,0),(1,1),(0,0),(0,0),(0,0), out_ready=1 -> out_bit 1,0,1,1, out_last on 4th, pm_final=0.
REQ-031 Same as REQ-030 with step-1 zk flipped to 0 -> out_bit 1,0,1,1, pm_final=1.
REQ-032 K=64, 67 pairs all (0,0) -> 64 zeros, out_last on 64th only, pm_final=0; first out_valid 67 cycles after last accepted symbol.
REQ-033 REQ-030 stream with out_ready low 5 cycles after 2nd bit -> out_bit=1 (3rd bit) held stable, total exactly 4 transfers.
REQ-034 K=0 then K=65 on first symbol -> k_err pulses each time, in_ready stays 1, no out_valid.
REQ-035 aclr_n low for 1 cycle after 3 symbols of a K=4 block, then REQ-030 stream -> IDLE next cycle, then correct REQ-030 output.

Source files
------------

// File: rtl/encoder_viterbi_dec_if.sv
// encoder_viterbi_dec_if: symbol-in / bit-out handshake bundle for the Viterbi decoder
//   K/in_valid/xk/zk/in_ready : block length and received symbol pairs into the decoder
//   out_valid/out_ready/out_bit/out_last/pm_final : decoded bits out, final state-0 metric
//   k_err : pulse when a block start carries an illegal K
interface encoder_viterbi_dec_if;
  logic [6:0] K;
  logic       in_valid, xk, zk, in_ready;
  logic       out_valid, out_ready, out_bit, out_last, k_err;
  logic [7:0] pm_final;
  modport master (output K, in_valid, xk, zk, out_ready,
                  input  in_ready, out_valid, out_bit, out_last, pm_final, k_err);
  modport slave  (input  K, in_valid, xk, zk, out_ready,
                  output in_ready, out_valid, out_bit, out_last, pm_final, k_err);
endinterface

// File: rtl/encoder_viterbi_dec.sv
// encoder_viterbi_dec: hard-decision Viterbi decoder for the 8-state RSC code with 3-step tail
//   clk    : rising-edge clock
//   aclr_n : synchronous active-low reset
//   bus    : slave side of encoder_viterbi_dec_if (symbol input, decoded bit output, k_err)
module encoder_viterbi_dec #(
  parameter int KMAX = 64
) (
  input logic                   clk,
  input logic                   aclr_n,
  encoder_viterbi_dec_if.slave  bus
);
  localparam int SW = $clog2(KMAX + 3);
  localparam logic [6:0] KMAX7 = 7'(KMAX);
  typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;
  state_t          r_state, w_next;
  logic [6:0]      r_k, w_k;
  logic [SW-1:0]   r_step, r_idx, w_ks;
  logic [2:0]      r_cur;
  logic [7:0]      r_pm [8];
  logic [7:0]      w_pm_src [8];
  logic [7:0]      w_pm_new [8];
  logic [7:0]      w_m0 [8];
  logic [7:0]      w_m1 [8];
  logic [7:0]      w_surv;
  logic [7:0]      r_surv [KMAX+3];
  logic            r_buf [KMAX+3];
  logic [7:0]      r_pm_final;
  logic            r_kerr, w_k_ok, w_acc, w_tail, w_last_step, w_xfer, w_out_last, w_p;
  // saturating path extension: metric plus Hamming distance of received vs expected pair
  function automatic logic [7:0] f_path(input logic [7:0] pm, input logic rx, rz, ex, ez);
    logic [8:0] s;
    s = {1'b0, pm} + 9'(rx ^ ex) + 9'(rz ^ ez);
    return s[8] ? 8'hff : s[7:0];
  endfunction
  assign w_k         = (r_state == IDLE) ? bus.K : r_k;
  assign w_ks        = SW'(w_k);
  assign w_k_ok      = bus.K != 7'd0 && bus.K <= KMAX7;
  assign w_acc       = bus.in_valid && (r_state == ACS || (r_state == IDLE && w_k_ok));
  assign w_tail      = r_step >= w_ks;
  assign w_last_step = r_step == w_ks + SW'(2);
  assign w_out_last  = r_idx == w_ks - SW'(1);
  assign w_xfer      = r_state == OUT && bus.out_ready;
  assign w_p         = r_surv[r_step][r_cur];
  assign bus.in_ready  = r_state == IDLE || r_state == ACS;
  assign bus.out_valid = r_state == OUT;
  assign bus.out_bit   = (r_state == OUT) ? r_buf[r_idx] : 1'b0;
  assign bus.out_last  = r_state == OUT && w_out_last;
  assign bus.pm_final  = r_pm_final;
  assign bus.k_err     = r_kerr;
  // Predecessors of next state n are {n.q1,n.q2,p}; expected pair is x=n.q0^n.q2^p, z=n.q0^n.q1^p.
  // During the tail fb is forced 0, so states with n.q0=1 are unreachable.
  always_comb begin
    for (int i = 0; i < 8; i++) w_pm_src[i] = (r_state == IDLE) ? ((i == 0) ? 8'h00 : 8'hff) : r_pm[i];
    for (int n = 0; n < 8; n++) begin
      w_m0[n]     = f_path(w_pm_src[{n[1:0], 1'b0}], bus.xk, bus.zk, n[2] ^ n[0], n[2] ^ n[1]);
      w_m1[n]     = f_path(w_pm_src[{n[1:0], 1'b1}], bus.xk, bus.zk, ~(n[2] ^ n[0]), ~(n[2] ^ n[1]));
      w_surv[n]   = (w_tail && n[2]) ? 1'b0 : (w_m1[n] < w_m0[n]);
      w_pm_new[n] = (w_tail && n[2]) ? 8'hff : (w_surv[n] ? w_m1[n] : w_m0[n]);
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = w_acc ? ACS : IDLE;
      ACS:   w_next = (w_acc && w_last_step) ? TRACE : ACS;
      TRACE: w_next = (r_step == '0) ? OUT : TRACE;
      OUT:   w_next = (w_xfer && w_out_last) ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!aclr_n) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      r_k        <= '0;
      r_step     <= '0;
      r_idx      <= '0;
      r_cur      <= '0;
      r_pm_final <= '0;
      r_kerr     <= 1'b0;
      for (int i = 0; i < 8; i++) r_pm[i] <= (i == 0) ? 8'h00 : 8'hff;
    end else begin
      r_kerr <= r_state == IDLE && bus.in_valid && !w_k_ok;
      if (w_acc) begin
        for (int i = 0; i < 8; i++) r_pm[i] <= w_pm_new[i];
        if (r_state == IDLE) r_k <= bus.K;
        if (w_last_step) begin
          r_pm_final <= w_pm_new[0];
          r_cur      <= '0;
        end else r_step <= r_step + SW'(1);
      end
      // trace walks r_step back from K+2 to 0, leaving it at 0 for the next block
      if (r_state == TRACE) begin
        r_cur <= {r_cur[1:0], w_p};
        if (r_step != '0) r_step <= r_step - SW'(1);
      end
      if (w_xfer) r_idx <= w_out_last ? '0 : r_idx + SW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) r_surv[r_step] <= w_surv;
    if (r_state == TRACE && w_tail == 1'b0) r_buf[r_step] <= r_cur[2] ^ r_cur[0] ^ w_p;
  end
endmodule
